// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, count type and flag bundle used by the timing
// generator and by downstream pixel generators.
package vga_timing_pkg;

  localparam int unsigned COUNT_W   = 11;
  localparam int unsigned COUNT_MAX = (1 << COUNT_W) - 1;

  typedef logic [COUNT_W-1:0] count_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;
  localparam int unsigned V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    logic blank;
    logic h_sync;
    logic v_sync;
    logic frame_start;
    logic line_start;
  } vga_flags_t;

  // Flags describing pixel (0,0): visible, both syncs idle, both start pulses high.
  localparam vga_flags_t FLAGS_RESET = '{
    blank:       1'b0,
    h_sync:      1'b1,
    v_sync:      1'b1,
    frame_start: 1'b1,
    line_start:  1'b1
  };

  function automatic logic in_window(count_t value, count_t lo, count_t hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the timing generator outputs; the generator drives it as master,
// pixel pipelines and monitors consume it as slave.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  count_t hCount;
  count_t vCount;
  logic   blank;
  logic   hSync;
  logic   vSync;
  logic   frame_start;
  logic   line_start;

  modport master (
    output hCount, vCount, blank, hSync, vSync, frame_start, line_start
  );

  modport slave (
    input hCount, vCount, blank, hSync, vSync, frame_start, line_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1 while enabled and
// exposes its next-state value so decode can stay aligned with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOTAL_DEF
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   en_i,
  output count_t count_o,
  output count_t count_d_o,
  output logic   tc_o
);

  localparam count_t LAST = count_t'(TOTAL - 1);

  count_t count_q;
  count_t count_d;
  logic   tc;

  assign tc = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (rst_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc ? '0 : count_q + count_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign tc_o      = tc;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus registered blank,
// sync and start strobes that always describe the counters shown alongside.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic   clk_25mhz,
  input  logic   reset,
  output count_t hCount,
  output count_t vCount,
  output logic   blank,
  output logic   hSync,
  output logic   vSync,
  output logic   frame_start,
  output logic   line_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COUNT_MAX) begin : g_h_total_too_large
    $error("vga_timing_gen: H_TOTAL %0d does not fit in %0d bits", H_TOTAL, COUNT_W);
  end
  if (V_TOTAL > COUNT_MAX) begin : g_v_total_too_large
    $error("vga_timing_gen: V_TOTAL %0d does not fit in %0d bits", V_TOTAL, COUNT_W);
  end

  localparam count_t H_VIS  = count_t'(H_VISIBLE);
  localparam count_t HS_LO  = count_t'(H_VISIBLE + H_FP);
  localparam count_t HS_HI  = count_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam count_t V_VIS  = count_t'(V_VISIBLE);
  localparam count_t VS_LO  = count_t'(V_VISIBLE + V_FP);
  localparam count_t VS_HI  = count_t'(V_VISIBLE + V_FP + V_SYNC);

  count_t     h_d;
  count_t     v_d;
  logic       h_tc;
  logic       v_tc;
  vga_flags_t flags_d;
  vga_flags_t flags_q;

  vga_axis_counter #(
    .TOTAL (H_TOTAL)
  ) u_h_counter (
    .clk_i     (clk_25mhz),
    .rst_i     (reset),
    .en_i      (1'b1),
    .count_o   (hCount),
    .count_d_o (h_d),
    .tc_o      (h_tc)
  );

  // The line counter only advances on the clock where the pixel counter wraps.
  vga_axis_counter #(
    .TOTAL (V_TOTAL)
  ) u_v_counter (
    .clk_i     (clk_25mhz),
    .rst_i     (reset),
    .en_i      (h_tc),
    .count_o   (vCount),
    .count_d_o (v_d),
    .tc_o      (v_tc)
  );

  // Decode works on the next-state counts so the registered flags land in the
  // same cycle as the counts they describe.
  always_comb begin
    flags_d             = FLAGS_RESET;
    flags_d.blank       = (h_d >= H_VIS) || (v_d >= V_VIS);
    flags_d.h_sync      = !in_window(h_d, HS_LO, HS_HI);
    flags_d.v_sync      = !in_window(v_d, VS_LO, VS_HI);
    flags_d.line_start  = reset || h_tc;
    flags_d.frame_start = reset || (h_tc && v_tc);
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      flags_q <= FLAGS_RESET;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign blank       = flags_q.blank;
  assign hSync       = flags_q.h_sync;
  assign vSync       = flags_q.v_sync;
  assign frame_start = flags_q.frame_start;
  assign line_start  = flags_q.line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default timing, a short-frame variant
// and an 800-wide variant, checked against hand-computed raster points.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int dut;
    int cyc;
    int h;
    int v;
    int b;
    int hs;
    int vs;
    int fs;
    int ls;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  logic rst_w = 1'b1;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  exp_t sb[$];

  int rd = -1000000;
  int rs = -1000000;
  int rw = -1000000;

  int ah[3], av[3], ab[3], ahs[3], avs[3], afs[3], als[3];

  // Aggregate measurements.
  int ls_cnt_d = 0, hs_low_d = 0, hs_first_d = -1, hs_last_d = -1;
  int blank_rise_d = -1, blank_fall_d = -1, prev_b_d = 0;
  int vs_low_s = 0, fs_cnt_s = 0;
  int ls_first_w = -1, hs_low_w = 0;

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_s ();
  vga_timing_gen_if if_w ();

  vga_timing_gen u_dut_d (
    .clk_25mhz   (clk),
    .reset       (rst_d),
    .hCount      (if_d.hCount),
    .vCount      (if_d.vCount),
    .blank       (if_d.blank),
    .hSync       (if_d.hSync),
    .vSync       (if_d.vSync),
    .frame_start (if_d.frame_start),
    .line_start  (if_d.line_start)
  );

  vga_timing_gen #(
    .V_VISIBLE (6),
    .V_FP      (2),
    .V_SYNC    (2),
    .V_BP      (2)
  ) u_dut_s (
    .clk_25mhz   (clk),
    .reset       (rst_s),
    .hCount      (if_s.hCount),
    .vCount      (if_s.vCount),
    .blank       (if_s.blank),
    .hSync       (if_s.hSync),
    .vSync       (if_s.vSync),
    .frame_start (if_s.frame_start),
    .line_start  (if_s.line_start)
  );

  vga_timing_gen #(
    .H_VISIBLE (800),
    .H_FP      (40),
    .H_SYNC    (128),
    .H_BP      (88)
  ) u_dut_w (
    .clk_25mhz   (clk),
    .reset       (rst_w),
    .hCount      (if_w.hCount),
    .vCount      (if_w.vCount),
    .blank       (if_w.blank),
    .hSync       (if_w.hSync),
    .vSync       (if_w.vSync),
    .frame_start (if_w.frame_start),
    .line_start  (if_w.line_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input int dut, input int ref_cyc, input int k, input int h, input int v,
                      input int b, input int hs, input int vs, input int fs, input int ls);
    exp_t e;
    e.dut = dut; e.cyc = ref_cyc + k; e.h = h; e.v = v;
    e.b = b; e.hs = hs; e.vs = vs; e.fs = fs; e.ls = ls;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    string t;
    t = $sformatf("dut%0d cyc%0d", e.dut, e.cyc);
    check({t, " hCount"},      ah[e.dut],  e.h);
    check({t, " vCount"},      av[e.dut],  e.v);
    check({t, " blank"},       ab[e.dut],  e.b);
    check({t, " hSync"},       ahs[e.dut], e.hs);
    check({t, " vSync"},       avs[e.dut], e.vs);
    check({t, " frame_start"}, afs[e.dut], e.fs);
    check({t, " line_start"},  als[e.dut], e.ls);
  endtask

  // Monitor: samples every DUT 2 time units after each rising edge.
  initial forever begin
    int kd, ks, kw;
    @(posedge clk);
    #2;
    ah[0] = int'(if_d.hCount); av[0] = int'(if_d.vCount); ab[0] = int'(if_d.blank);
    ahs[0] = int'(if_d.hSync); avs[0] = int'(if_d.vSync);
    afs[0] = int'(if_d.frame_start); als[0] = int'(if_d.line_start);
    ah[1] = int'(if_s.hCount); av[1] = int'(if_s.vCount); ab[1] = int'(if_s.blank);
    ahs[1] = int'(if_s.hSync); avs[1] = int'(if_s.vSync);
    afs[1] = int'(if_s.frame_start); als[1] = int'(if_s.line_start);
    ah[2] = int'(if_w.hCount); av[2] = int'(if_w.vCount); ab[2] = int'(if_w.blank);
    ahs[2] = int'(if_w.hSync); avs[2] = int'(if_w.vSync);
    afs[2] = int'(if_w.frame_start); als[2] = int'(if_w.line_start);

    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_chk++;
        $display("FAIL missed dut%0d cyc%0d: got no sample, expected one", sb[i].dut, sb[i].cyc);
        sb.delete(i);
      end
    end

    kd = cyc - rd;
    if (kd >= 1 && kd <= 800) begin
      ls_cnt_d += als[0];
      if (ahs[0] == 0) begin
        hs_low_d++;
        if (hs_first_d < 0) hs_first_d = ah[0];
        hs_last_d = ah[0];
      end
      if (ab[0] == 1 && prev_b_d == 0 && blank_rise_d < 0) blank_rise_d = ah[0];
      if (ab[0] == 0 && prev_b_d == 1 && blank_fall_d < 0) blank_fall_d = ah[0];
    end
    prev_b_d = ab[0];

    ks = cyc - rs;
    if (ks >= 1 && ks <= 9600) begin
      if (avs[1] == 0) vs_low_s++;
      fs_cnt_s += afs[1];
    end

    kw = cyc - rw;
    if (kw >= 1 && kw <= 1056) begin
      if (ahs[2] == 0) hs_low_w++;
      if (als[2] == 1 && ls_first_w < 0) ls_first_w = kw;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: dut, ref, k, h, v, blank, hSync, vSync, frame_start, line_start
  initial begin
    int r;
    int r2;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) push(d, cyc, 1, 0, 0, 0, 1, 1, 1, 1);
    @(negedge clk);
    r = cyc;
    rst_d = 1'b0; rst_s = 1'b0; rst_w = 1'b0;
    rd = r; rs = r; rw = r;

    push(0, r,    1,   1, 0, 0, 1, 1, 0, 0);
    push(0, r,  639, 639, 0, 0, 1, 1, 0, 0);
    push(0, r,  640, 640, 0, 1, 1, 1, 0, 0);
    push(0, r,  655, 655, 0, 1, 1, 1, 0, 0);
    push(0, r,  656, 656, 0, 1, 0, 1, 0, 0);
    push(0, r,  751, 751, 0, 1, 0, 1, 0, 0);
    push(0, r,  752, 752, 0, 1, 1, 1, 0, 0);
    push(0, r,  799, 799, 0, 1, 1, 1, 0, 0);
    push(0, r,  800,   0, 1, 0, 1, 1, 0, 1);
    push(0, r,  801,   1, 1, 0, 1, 1, 0, 0);

    push(1, r, 4010,  10,  5, 0, 1, 1, 0, 0);
    push(1, r, 4799, 799,  5, 1, 1, 1, 0, 0);
    push(1, r, 4800,   0,  6, 1, 1, 1, 0, 1);
    push(1, r, 6399, 799,  7, 1, 1, 1, 0, 0);
    push(1, r, 6400,   0,  8, 1, 1, 0, 0, 1);
    push(1, r, 7100, 700,  8, 1, 0, 0, 0, 0);
    push(1, r, 7999, 799,  9, 1, 1, 0, 0, 0);
    push(1, r, 8000,   0, 10, 1, 1, 1, 0, 1);
    push(1, r, 9599, 799, 11, 1, 1, 1, 0, 0);
    push(1, r, 9600,   0,  0, 0, 1, 1, 1, 1);
    push(1, r, 9601,   1,  0, 0, 1, 1, 0, 0);
    push(1, r, 14300, 700, 5, 1, 0, 1, 0, 0);
    push(1, r, 14301,   0, 0, 0, 1, 1, 1, 1);
    push(1, r, 14302,   1, 0, 0, 1, 1, 0, 0);

    push(2, r,  799,  799, 0, 0, 1, 1, 0, 0);
    push(2, r,  800,  800, 0, 1, 1, 1, 0, 0);
    push(2, r,  839,  839, 0, 1, 1, 1, 0, 0);
    push(2, r,  840,  840, 0, 1, 0, 1, 0, 0);
    push(2, r,  967,  967, 0, 1, 0, 1, 0, 0);
    push(2, r,  968,  968, 0, 1, 1, 1, 0, 0);
    push(2, r, 1055, 1055, 0, 1, 1, 1, 0, 0);
    push(2, r, 1056,    0, 1, 0, 1, 1, 0, 1);

    // One-cycle reset on the short-frame unit at (700,5) of its second frame.
    while (cyc < r + 14300) @(negedge clk);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    r2 = cyc;
    push(1, r2, 799, 799, 0, 1, 1, 1, 0, 0);
    push(1, r2, 800,   0, 1, 0, 1, 1, 0, 1);

    while (cyc < r2 + 805) @(negedge clk);

    check("pending expectations", sb.size(), 0);
    check("dut0 line_start pulses in line", ls_cnt_d, 1);
    check("dut0 hSync low cycles", hs_low_d, 96);
    check("dut0 hSync low first hCount", hs_first_d, 656);
    check("dut0 hSync low last hCount", hs_last_d, 751);
    check("dut0 blank rise hCount", blank_rise_d, 640);
    check("dut0 blank fall hCount", blank_fall_d, 0);
    check("dut1 vSync low cycles per frame", vs_low_s, 1600);
    check("dut1 frame_start pulses per frame", fs_cnt_s, 1);
    check("dut2 line period", ls_first_w, 1056);
    check("dut2 hSync low cycles", hs_low_w, 128);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in clocks.
REQ-005 The block SHALL have parameters V_VISIBLE=480, V_FP=10, V_SYNC=2 and V_BP=33, meaning the vertical equivalents, in lines.
REQ-006 The block SHALL have port clk_25mhz, input, 1 bit: the single clock, one pixel per cycle.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port hCount, output, 11 bits: current pixel column.
REQ-009 The block SHALL have port vCount, output, 11 bits: current line.
REQ-010 The block SHALL have port blank, output, 1 bit: high outside the visible region.
REQ-011 The block SHALL have port hSync, output, 1 bit: horizontal sync, active-low.
REQ-012 The block SHALL have port vSync, output, 1 bit: vertical sync, active-low.
REQ-013 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at pixel (0,0).
REQ-014 The block SHALL have port line_start, output, 1 bit: one-cycle pulse at every hCount==0.

Function
REQ-015 The block SHALL set H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 by default) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 by default).
REQ-016 hCount SHALL increment by 1 every clock and wrap from H_TOTAL-1 to 0 on the next clock.
REQ-017 vCount SHALL increment only on the clock where hCount wraps, and SHALL wrap from V_TOTAL-1 to 0 when hCount also wraps.
REQ-018 blank SHALL be high iff hCount >= H_VISIBLE or vCount >= V_VISIBLE; by default it is low for hCount 0..639 with vCount 0..479.
REQ-019 hSync SHALL be low iff H_VISIBLE+H_FP <= hCount < H_VISIBLE+H_FP+H_SYNC (656..751 by default).
REQ-020 vSync SHALL be low iff V_VISIBLE+V_FP <= vCount < V_VISIBLE+V_FP+V_SYNC (490..491 by default), independent of hCount.
REQ-021 All outputs SHALL be registered and cycle-coherent: blank, hSync, vSync, frame_start and line_start SHALL describe the hCount/vCount pair presented in the same cycle, with zero cycles of skew.
REQ-022 Decode SHALL be computed from next-state counter values so that no output lags the counters.
REQ-023 frame_start SHALL be high iff hCount==0 and vCount==0; line_start SHALL be high iff hCount==0.
REQ-024 Counter arithmetic SHALL be unsigned 11-bit; parameters with H_TOTAL or V_TOTAL > 2047 SHALL be rejected at elaboration.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL set hCount=0, vCount=0, blank=0, hSync=1, vSync=1, frame_start=1 and line_start=1.
REQ-026 On the first edge with reset low, the block SHALL present hCount=1, vCount=0 and frame_start=0.
REQ-027 Reset asserted mid-frame SHALL take effect on the next edge, with no partial-line completion.

Structure
REQ-028 Default timing constants, the derived totals and the 11-bit count width SHALL reside in shared package vga_timing_pkg, which pixel generators SHALL also use.
REQ-029 One sub-module, vga_axis_counter, SHALL be used: a parameterised wrap counter with an enable input and a terminal-count output, instantiated once for horizontal and once for vertical.

Verification
REQ-030 Release reset, then run 800 clocks -> hCount runs 1..799 then 0, vCount steps 0->1 exactly at the wrap, and line_start pulses once.
REQ-031 Sample one line -> hSync is low for exactly 96 consecutive cycles, starting at hCount=656; blank rises at hCount=640 and falls at 0.
REQ-032 Run one full frame (420000 clocks) -> vSync is low for exactly 1600 clocks (vCount 490..491), and frame_start pulses exactly once per 420000 clocks.
REQ-033 Observe the wrap at hCount=799, vCount=524 -> the next cycle shows (0,0) with blank=0 and frame_start=1.
REQ-034 Assert reset for 1 cycle at hCount=700, vCount=300 -> the next cycle shows (0,0) with hSync=1 and vSync=1, and counting resumes from 1.
REQ-035 Elaborate with non-default parameters H_VISIBLE=800, H_FP=40, H_SYNC=128, H_BP=88 -> the line period is 1056 clocks and hSync is low for hCount 840..967.
